// File: rtl/game_ctrl.sv
// game_ctrl: top-level sequencer for a memory/sequence game.
// Moves through fill -> playback -> pause -> player entry for four rounds
// and reports win or lose. Every output is a pure decode of the registered
// state and level, so no input reaches an output combinationally.
module game_ctrl #(
  parameter int GAP     = 4,      // PAUSE length in cycles (1..255)
  parameter int TIMEOUT = 50000   // max cycles in INPUT before a loss (1..65535)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       complete_IDLE,
  input  logic       complete_DISP,
  input  logic       complete_INPUT,
  input  logic       input_match,
  output logic       en_IDLE,
  output logic       rst_IDLE,
  output logic       en_DISP,
  output logic       rst_DISP,
  output logic       en_INPUT,
  output logic       rst_INPUT,
  output logic [1:0] level,
  output logic       win,
  output logic       lose,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_WAIT  = 3'b000,
    ST_FILL  = 3'b001,
    ST_SHOW  = 3'b010,
    ST_PAUSE = 3'b011,
    ST_INPUT = 3'b100,
    ST_NEXT  = 3'b101,
    ST_WIN   = 3'b110,
    ST_LOSE  = 3'b111
  } state_t;

  // Terminal counts: PAUSE lasts GAP cycles, INPUT at most TIMEOUT cycles.
  localparam logic [7:0]  GAP_LAST = 8'(GAP - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [1:0]  LVL_MAX  = 2'd3;

  state_t      state_r;
  state_t      next_state_s;
  logic [1:0]  level_r;
  logic [1:0]  next_level_s;
  logic [7:0]  gap_cnt_r;
  logic [7:0]  next_gap_cnt_s;
  logic [15:0] to_cnt_r;
  logic [15:0] next_to_cnt_s;

  // State, level and counter registers; async reset returns to WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_WAIT;
      level_r   <= 2'd0;
      gap_cnt_r <= 8'd0;
      to_cnt_r  <= 16'd0;
    end else begin
      state_r   <= next_state_s;
      level_r   <= next_level_s;
      gap_cnt_r <= next_gap_cnt_s;
      to_cnt_r  <= next_to_cnt_s;
    end
  end

  // Next-state logic; counters fall back to zero whenever their state is left.
  always_comb begin
    next_state_s   = state_r;
    next_level_s   = level_r;
    next_gap_cnt_s = 8'd0;
    next_to_cnt_s  = 16'd0;
    case (state_r)
      ST_WAIT: begin
        if (start) begin
          next_state_s = ST_FILL;
          next_level_s = 2'd0;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_FILL: begin
        if (complete_IDLE) begin
          next_state_s = ST_SHOW;
        end else begin
          next_state_s = ST_FILL;
        end
      end
      ST_SHOW: begin
        if (complete_DISP) begin
          next_state_s = ST_PAUSE;
        end else begin
          next_state_s = ST_SHOW;
        end
      end
      ST_PAUSE: begin
        if (gap_cnt_r == GAP_LAST) begin
          next_state_s = ST_INPUT;
        end else begin
          next_state_s   = ST_PAUSE;
          next_gap_cnt_s = gap_cnt_r + 8'd1;
        end
      end
      ST_INPUT: begin
        // A completed entry wins over a timeout expiring in the same cycle.
        if (complete_INPUT) begin
          if (!input_match) begin
            next_state_s = ST_LOSE;
          end else if (level_r == LVL_MAX) begin
            next_state_s = ST_WIN;
          end else begin
            next_state_s = ST_NEXT;
          end
        end else if (to_cnt_r == TO_LAST) begin
          next_state_s = ST_LOSE;
        end else begin
          next_state_s  = ST_INPUT;
          next_to_cnt_s = to_cnt_r + 16'd1;
        end
      end
      ST_NEXT: begin
        next_state_s = ST_SHOW;
        // Guard keeps level from wrapping even if NEXT were reached at the top.
        if (level_r != LVL_MAX) begin
          next_level_s = level_r + 2'd1;
        end else begin
          next_level_s = level_r;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (start) begin
          next_state_s = ST_FILL;
          next_level_s = 2'd0;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = ST_WAIT;
        next_level_s = 2'd0;
      end
    endcase
  end

  // Moore output decode: each sub-block is enabled only in its own state and
  // held in reset everywhere else.
  always_comb begin
    en_IDLE   = 1'b0;
    rst_IDLE  = 1'b1;
    en_DISP   = 1'b0;
    rst_DISP  = 1'b1;
    en_INPUT  = 1'b0;
    rst_INPUT = 1'b1;
    case (state_r)
      ST_FILL: begin
        en_IDLE  = 1'b1;
        rst_IDLE = 1'b0;
      end
      ST_SHOW: begin
        en_DISP  = 1'b1;
        rst_DISP = 1'b0;
      end
      ST_INPUT: begin
        en_INPUT  = 1'b1;
        rst_INPUT = 1'b0;
      end
      default: begin
        en_IDLE   = 1'b0;
        rst_IDLE  = 1'b1;
        en_DISP   = 1'b0;
        rst_DISP  = 1'b1;
        en_INPUT  = 1'b0;
        rst_INPUT = 1'b1;
      end
    endcase
  end

  assign win   = (state_r == ST_WIN);
  assign lose  = (state_r == ST_LOSE);
  assign level = level_r;
  assign state = state_r;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL provide parameter GAP, default 4, cycles spent in PAUSE between playback and player input (legal range 1..255).
REQ-002 SHALL provide parameter TIMEOUT, default 50000, maximum cycles allowed in INPUT before a loss (legal range 1..65535).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  player start/restart request, sampled on clk.
REQ-006 complete_IDLE  input  1  memory-fill block done.
REQ-007 complete_DISP  input  1  sequence-playback block done.
REQ-008 complete_INPUT  input  1  player-entry block done.
REQ-009 input_match  input  1  entry correct; qualified only by complete_INPUT.
REQ-010 en_IDLE, rst_IDLE  output  1 each  enable/sync reset of memory-fill block.
REQ-011 en_DISP, rst_DISP  output  1 each  enable/sync reset of playback block.
REQ-012 en_INPUT, rst_INPUT  output  1 each  enable/sync reset of player-entry block.
REQ-013 level  output  2  current round; playback/entry length = level+1.
REQ-014 win, lose  output  1 each  game result flags.
REQ-015 state  output  3  current state encoding, for debug.

Function
REQ-016 SHALL implement states WAIT=000, FILL=001, SHOW=010, PAUSE=011, INPUT=100, NEXT=101, WIN=110, LOSE=111.
REQ-017 All outputs SHALL be decoded from registered state/level only (Moore); no input-to-output combinational path.
REQ-018 en_X SHALL be 1 only in its own state: en_IDLE in FILL, en_DISP in SHOW, en_INPUT in INPUT.
REQ-019 rst_X SHALL be 1 in every state except its own enabling state (WAIT holds all three in reset).
REQ-020 WAIT: start=1 -> FILL, level<=0.
REQ-021 FILL: complete_IDLE=1 -> SHOW.
REQ-022 SHOW: complete_DISP=1 -> PAUSE, gap counter <=0.
REQ-023 PAUSE: SHALL remain exactly GAP cycles, then -> INPUT with timeout counter <=0.
REQ-024 INPUT: complete_INPUT=1 and input_match=0 -> LOSE.
REQ-025 INPUT: complete_INPUT=1, input_match=1, level=3 -> WIN.
REQ-026 INPUT: complete_INPUT=1, input_match=1, level<3 -> NEXT.
REQ-027 INPUT: timeout counter reaching TIMEOUT-1 without complete_INPUT -> LOSE (i.e. TIMEOUT cycles in INPUT).
REQ-028 Same-cycle complete_INPUT and timeout expiry: complete_INPUT SHALL take priority.
REQ-029 NEXT: single cycle; level<=level+1; -> SHOW (playback restarts from reset, since rst_DISP=1 in NEXT).
REQ-030 WIN: win=1 held; start=1 -> FILL, level<=0, win clears on leaving.
REQ-031 LOSE: lose=1 held; start=1 -> FILL, level<=0, lose clears on leaving.
REQ-032 start SHALL be ignored in FILL, SHOW, PAUSE, INPUT, NEXT.
REQ-033 complete_* and input_match SHALL be ignored outside the state that consumes them.
REQ-034 level SHALL never wrap; increment only occurs from level<=2.
REQ-035 Gap counter 8 bits, timeout counter 16 bits; both held at 0 outside their state.

Reset
REQ-036 rst=1 SHALL immediately (no clock) force state=WAIT, level=0, counters=0, win=0, lose=0, all en_*=0, all rst_*=1.
REQ-037 Reset asserted mid-game (any state) SHALL abandon the round; first clocked action after release is WAIT evaluation of start.
REQ-038 Deassertion SHALL be accepted on any edge; no state change in the release cycle unless start=1.

Verification
REQ-039 Full win: start, complete_IDLE, then 4x(complete_DISP, wait GAP=4, complete_INPUT+match) -> level 0,1,2,3 per round, state=110, win=1.
REQ-040 Loss on mismatch: at level=1 INPUT, complete_INPUT=1, input_match=0 -> state=111, lose=1, level stays 1; start -> FILL, level=0, lose=0.
REQ-041 Timeout: TIMEOUT=10, no complete_INPUT -> exactly 10 cycles in INPUT, then LOSE; complete_INPUT on 10th cycle -> NEXT instead.
REQ-042 PAUSE timing: complete_DISP in cycle N -> PAUSE cycles N+1..N+GAP, en_INPUT=1 in cycle N+GAP+1.
REQ-043 Async reset in SHOW at level=2, between clock edges -> outputs reach reset values without a clock edge; start pulse during FILL/SHOW ignored afterwards.
REQ-044 Spurious inputs: complete_DISP/complete_INPUT pulses in WAIT and FILL -> no state change.
